ram_ctrl: RTL and testbench

Backing-memory controller directly downstream of the cache control FSM (muu).
- Consumes the rdram/wrram strobes issued on a miss or write-back.
- Performs the line access against an internal behavioural line store with a fixed, parameterised latency.
- Returns the 64-bit fill line on rdata together with a one-cycle ram_ack pulse; rdata feeds the line-merge mux and ram_ack feeds the FSM.

---
 rtl/ram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Backing-memory controller: fixed-latency line read/write against an internal line store.
// Optional RAM_CTRL_STATS_EN adds saturating read/write commit counters (rd_cnt, wr_cnt).
module ram_ctrl #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rdram,
    input  logic        wrram,
    input  logic [13:0] rd_addr,
    input  logic [13:0] wr_addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        ram_ack,
    output logic        busy
`ifdef RAM_CTRL_STATS_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        ACK
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("ram_ctrl: LATENCY must be in 1..15");
    end

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    pend_rd_q;
    logic [DEPTH_LOG2-1:0]   rd_idx_q;
    logic [DEPTH_LOG2-1:0]   wr_idx_q;
    logic [63:0]             wdata_q;
    logic [63:0]             rdata_q;
    logic                    ack_q;
    logic                    busy_q;
    logic [63:0]             mem_q [DEPTH];

    logic                    wr_commit;
    logic                    rd_commit;

    // Address bits above the line index alias onto the same line.
    if (DEPTH_LOG2 < 14) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{rd_addr[13:DEPTH_LOG2], wr_addr[13:DEPTH_LOG2]};
    end

    always_comb begin
        wr_commit = (state_q == WR_WAIT) && (cnt_q == '0);
        rd_commit = (state_q == RD_WAIT) && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rd_q <= 1'b0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (wrram) begin
                        wr_idx_q  <= wr_addr[DEPTH_LOG2-1:0];
                        wdata_q   <= wdata;
                        pend_rd_q <= rdram;
                        if (rdram) begin
                            rd_idx_q <= rd_addr[DEPTH_LOG2-1:0];
                        end
                        cnt_q   <= CNT_LOAD;
                        state_q <= WR_WAIT;
                        busy_q  <= 1'b1;
                    end else if (rdram) begin
                        rd_idx_q <= rd_addr[DEPTH_LOG2-1:0];
                        cnt_q    <= CNT_LOAD;
                        state_q  <= RD_WAIT;
                        busy_q   <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == '0) begin
                        // Write lands first, so a paired read of the same line sees new data.
                        if (pend_rd_q) begin
                            cnt_q     <= CNT_LOAD;
                            pend_rd_q <= 1'b0;
                            state_q   <= RD_WAIT;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= mem_q[rd_idx_q];
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line store is deliberately not reset; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[wr_idx_q] <= wdata_q;
        end
    end

    assign rdata   = rdata_q;
    assign ram_ack = ack_q;
    assign busy    = busy_q;

`ifdef RAM_CTRL_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_commit && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_commit && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    logic unused_rd_commit;
    assign unused_rd_commit = rd_commit;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios plus randomized traffic against a line-store model.
module tb_ram_ctrl;

    localparam int unsigned LAT = 3;
    localparam int unsigned DL2 = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rdram;
    logic        wrram;
    logic [13:0] rd_addr;
    logic [13:0] wr_addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ram_ack;
    logic        busy;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    int unsigned rd_n = 0;
    int unsigned wr_n = 0;
`endif

    int passed = 0;
    int total  = 0;

    logic [63:0] model_mem [256];
    logic [63:0] model_rdata;

    always #5 clk = ~clk;

    ram_ctrl #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rdram   (rdram),
        .wrram   (wrram),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ram_ack (ram_ack),
        .busy    (busy)
`ifdef RAM_CTRL_STATS_EN
        ,
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
`endif
    );

    // One transaction presented for a single cycle; cycle c is the c-th cycle after the request cycle.
    task automatic do_txn(input bit do_wr, input bit do_rd, input logic [13:0] wa,
                          input logic [13:0] ra, input logic [63:0] wd, input bit inject,
                          input string tag);
        int unsigned exp_lat;
        int unsigned ack_cnt;
        int unsigned ack_at;
        int unsigned busy_err;
        logic [7:0]  widx;
        logic [7:0]  ridx;
        exp_lat = (do_wr && do_rd) ? 2 * LAT + 1 : LAT + 1;
        widx = wa[7:0];
        ridx = ra[7:0];
        wrram = do_wr; rdram = do_rd; wr_addr = wa; rd_addr = ra; wdata = wd;
        if (do_wr) model_mem[widx] = wd;
        if (do_rd) model_rdata = model_mem[ridx];
`ifdef RAM_CTRL_STATS_EN
        if (do_wr) wr_n++;
        if (do_rd) rd_n++;
`endif
        ack_cnt = 0; ack_at = 0; busy_err = 0;
        for (int c = 1; c <= int'(2 * LAT + 4); c++) begin
            @(negedge clk);
            if (c == 1) begin wrram = 1'b0; rdram = 1'b0; end
            if (inject && c == 2) begin rdram = 1'b1; rd_addr = ra ^ 14'h0055; end
            if (inject && c == 3) rdram = 1'b0;
            if (ram_ack === 1'b1) begin ack_cnt++; ack_at = c; end
            if (busy !== ((c <= int'(exp_lat)) ? 1'b1 : 1'b0)) busy_err++;
        end
        total++;
        if (ack_cnt !== 1) $display("FAIL %s ack_count: got %0d expected 1", tag, ack_cnt);
        else passed++;
        total++;
        if (ack_at !== exp_lat) $display("FAIL %s ack_latency: got %0d expected %0d", tag, ack_at, exp_lat);
        else passed++;
        total++;
        if (busy_err !== 0) $display("FAIL %s busy_window: got %0d bad cycles expected 0", tag, busy_err);
        else passed++;
        total++;
        if (rdata !== model_rdata) $display("FAIL %s rdata: got %h expected %h", tag, rdata, model_rdata);
        else passed++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; rdram = 1'b0; wrram = 1'b0;
        rd_addr = '0; wr_addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
        total++;
        if (ram_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ram_ack); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
`ifdef RAM_CTRL_STATS_EN
        total++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0)
            $display("FAIL reset_stats: got %h/%h expected 0/0", rd_cnt, wr_cnt);
        else passed++;
`endif
        reset_n = 1'b1;
        model_rdata = '0;
        @(negedge clk);
    endtask

    task automatic init_store;
        for (int i = 0; i < 256; i++) do_txn(1'b1, 1'b0, 14'(i), 14'h0, 64'h0, 1'b0, "init");
    endtask

    task automatic test_read;
        do_txn(1'b0, 1'b1, 14'h0, 14'h0040, 64'h0, 1'b0, "read_0040");
    endtask

    task automatic test_write_readback;
        do_txn(1'b1, 1'b0, 14'h0005, 14'h0, 64'h0123_4567_89AB_CDEF, 1'b0, "write_0005");
        do_txn(1'b0, 1'b1, 14'h0, 14'h0005, 64'h0, 1'b0, "readback_0005");
    endtask

    task automatic test_combined;
        do_txn(1'b1, 1'b1, 14'h0010, 14'h0010, 64'hAAAA, 1'b0, "combined_0010");
    endtask

    task automatic test_busy_reject;
        do_txn(1'b1, 1'b0, 14'h0020, 14'h0, 64'hDEAD_BEEF_0000_0020, 1'b0, "prep_0020");
        do_txn(1'b0, 1'b1, 14'h0, 14'h0020, 64'h0, 1'b1, "busy_reject");
    endtask

    task automatic test_alias;
        do_txn(1'b1, 1'b0, 14'h0103, 14'h0, 64'h55, 1'b0, "alias_wr_0103");
        do_txn(1'b0, 1'b1, 14'h0, 14'h0003, 64'h0, 1'b0, "alias_rd_0003");
    endtask

    // Strobe held through the ack is taken as a second request once IDLE is reached.
    task automatic test_back_to_back;
        int unsigned acks;
        int unsigned first_at;
        int unsigned second_at;
        rdram = 1'b1; rd_addr = 14'h0005;
        model_rdata = model_mem[8'h05];
`ifdef RAM_CTRL_STATS_EN
        rd_n += 2;
`endif
        acks = 0; first_at = 0; second_at = 0;
        for (int c = 1; c <= int'(2 * LAT + 6); c++) begin
            @(negedge clk);
            if (c == int'(LAT + 3)) rdram = 1'b0;
            if (ram_ack === 1'b1) begin
                acks++;
                if (acks == 1) first_at = c; else second_at = c;
            end
        end
        total++;
        if (acks !== 2) $display("FAIL b2b_ack_count: got %0d expected 2", acks); else passed++;
        total++;
        if (first_at !== LAT + 1 || second_at !== 2 * LAT + 3)
            $display("FAIL b2b_ack_cycles: got %0d,%0d expected %0d,%0d", first_at, second_at, LAT + 1, 2 * LAT + 3);
        else passed++;
        total++;
        if (rdata !== model_rdata) $display("FAIL b2b_rdata: got %h expected %h", rdata, model_rdata); else passed++;
    endtask

    task automatic test_reset_mid_write;
        bit ack_seen;
        do_txn(1'b1, 1'b0, 14'h0007, 14'h0, 64'h1111, 1'b0, "prior_0007");
        wrram = 1'b1; wr_addr = 14'h0007; wdata = 64'hFF;
        @(negedge clk);
        wrram = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        ack_seen = 1'b0;
        repeat (2 * LAT + 2) begin
            @(negedge clk);
            if (ram_ack === 1'b1) ack_seen = 1'b1;
        end
        total++;
        if (ack_seen !== 1'b0) $display("FAIL rst_mid_no_ack: got %b expected 0", ack_seen); else passed++;
        total++;
        if (rdata !== 64'h0) $display("FAIL rst_mid_rdata: got %h expected 0", rdata); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
`ifdef RAM_CTRL_STATS_EN
        total++;
        if (wr_cnt !== 16'h0) $display("FAIL rst_mid_wr_cnt: got %h expected 0", wr_cnt); else passed++;
        rd_n = 0; wr_n = 0;
`endif
        reset_n = 1'b1;
        model_rdata = '0;
        @(negedge clk);
        do_txn(1'b0, 1'b1, 14'h0, 14'h0007, 64'h0, 1'b0, "rst_mid_readback");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            logic [13:0] wa;
            logic [13:0] ra;
            logic [63:0] wd;
            kind = $urandom_range(0, 2);
            wa = 14'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 14'($urandom);
            wd = {$urandom, $urandom};
            do_txn(kind != 1, kind != 0, wa, ra, wd, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        init_store();
        test_read();
        test_write_readback();
        test_combined();
        test_busy_reject();
        test_alias();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
`ifdef RAM_CTRL_STATS_EN
        total++;
        if (rd_cnt !== 16'(rd_n)) $display("FAIL stats_rd_cnt: got %0d expected %0d", rd_cnt, rd_n); else passed++;
        total++;
        if (wr_cnt !== 16'(wr_n)) $display("FAIL stats_wr_cnt: got %0d expected %0d", wr_cnt, wr_n); else passed++;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
